// File: rtl/mult_seq_hilo.sv
// Multi-cycle MULT/MULTU unit: walks 5-bit operand digits through one 5x5 core,
// accumulates shifted partial products, sign-corrects, and owns HI/LO.

module wallace_five (
  input  logic [4:0] a,
  input  logic [4:0] b,
  output logic [9:0] p
);
  logic [9:0] pp0_s, pp1_s, pp2_s, pp3_s, pp4_s;
  logic [9:0] s1_s, c1_s, s2_s, c2_s, s3_s, c3_s;

  // Partial products followed by a chain of 3:2 carry-save compressors.
  always_comb begin
    pp0_s = b[0] ? {5'd0, a}        : 10'd0;
    pp1_s = b[1] ? {4'd0, a, 1'b0}  : 10'd0;
    pp2_s = b[2] ? {3'd0, a, 2'b00} : 10'd0;
    pp3_s = b[3] ? {2'd0, a, 3'b000} : 10'd0;
    pp4_s = b[4] ? {1'd0, a, 4'b0000} : 10'd0;
    s1_s  = pp0_s ^ pp1_s ^ pp2_s;
    c1_s  = ((pp0_s & pp1_s) | (pp0_s & pp2_s) | (pp1_s & pp2_s)) << 1;
    s2_s  = s1_s ^ c1_s ^ pp3_s;
    c2_s  = ((s1_s & c1_s) | (s1_s & pp3_s) | (c1_s & pp3_s)) << 1;
    s3_s  = s2_s ^ c2_s ^ pp4_s;
    c3_s  = ((s2_s & c2_s) | (s2_s & pp4_s) | (c2_s & pp4_s)) << 1;
    p     = s3_s + c3_s;
  end
endmodule

module mult_seq_hilo #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int         EXT  = 5 * DIGITS;
  localparam logic [2:0] LAST = 3'(DIGITS - 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]         state_r, state_nx_s;
  logic [EXT-1:0]     ma_r, mb_r;
  logic               neg_r;
  logic [2*WIDTH-1:0] acc_r, pp_s, fix_s;
  logic [2:0]         i_r, j_r;
  logic [WIDTH-1:0]   hi_r, lo_r;
  logic               busy_r, done_r, busy_nx_s, done_nx_s;
  logic [4:0]         da_s, db_s;
  logic [9:0]         prod_s;
  logic [3:0]         dsum_s;
  logic [5:0]         shift_s;

  function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] x, input logic sgn);
    if (sgn && x[WIDTH-1]) mag_f = ~x + 32'd1;
    else                   mag_f = x;
  endfunction

  function automatic logic [4:0] digit_f(input logic [EXT-1:0] v, input logic [2:0] k);
    case (k)
      3'd0:    digit_f = v[4:0];
      3'd1:    digit_f = v[9:5];
      3'd2:    digit_f = v[14:10];
      3'd3:    digit_f = v[19:15];
      3'd4:    digit_f = v[24:20];
      3'd5:    digit_f = v[29:25];
      3'd6:    digit_f = v[34:30];
      default: digit_f = 5'd0;
    endcase
  endfunction

  wallace_five u_core (.a(da_s), .b(db_s), .p(prod_s));

  // Digit selection and weight of the current partial product: 5*(i+j).
  always_comb begin
    da_s    = digit_f(ma_r, i_r);
    db_s    = digit_f(mb_r, j_r);
    dsum_s  = {1'b0, i_r} + {1'b0, j_r};
    shift_s = {dsum_s, 2'b00} + {2'b00, dsum_s};
    pp_s    = {54'd0, prod_s} << shift_s;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nx_s;
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = IDLE;
    case (state_r)
      IDLE: if (start) state_nx_s = CALC; else state_nx_s = IDLE;
      CALC: if (i_r == LAST && j_r == LAST) state_nx_s = FIX; else state_nx_s = CALC;
      FIX:  state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Output decode; busy stays up through the done cycle.
  always_comb begin
    busy_nx_s = 1'b0;
    done_nx_s = 1'b0;
    fix_s     = acc_r;
    if (state_nx_s != IDLE || state_r == FIX) busy_nx_s = 1'b1;
    else                                      busy_nx_s = 1'b0;
    if (state_r == FIX) done_nx_s = 1'b1;
    else                done_nx_s = 1'b0;
    if (neg_r) fix_s = ~acc_r + 64'd1;
    else       fix_s = acc_r;
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_nx_s;
      done_r <= done_nx_s;
    end
  end

  // Operand latch, accumulator, digit counters and HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma_r  <= '0;
      mb_r  <= '0;
      neg_r <= 1'b0;
      acc_r <= '0;
      i_r   <= 3'd0;
      j_r   <= 3'd0;
      hi_r  <= '0;
      lo_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            ma_r  <= EXT'(mag_f(a, is_signed));
            mb_r  <= EXT'(mag_f(b, is_signed));
            neg_r <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc_r <= '0;
            i_r   <= 3'd0;
            j_r   <= 3'd0;
          end
          if (hi_we) hi_r <= wdata;
          if (lo_we) lo_r <= wdata;
        end
        CALC: begin
          acc_r <= acc_r + pp_s;
          if (j_r == LAST) begin
            j_r <= 3'd0;
            i_r <= i_r + 3'd1;
          end else begin
            j_r <= j_r + 3'd1;
          end
        end
        FIX: {hi_r, lo_r} <= fix_s;
        default: ;
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;
endmodule

// File: tb/tb_mult_seq_hilo.sv
// Directed self-checking bench for mult_seq_hilo.
module tb_mult_seq_hilo;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mult_seq_hilo dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one multiply and watch 70 cycles; optional injection of a second
  // start at E10 and an MTLO at E20 while busy.
  task automatic run_mul(input string tag, input logic sgn, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] eh,
                         input logic [31:0] el, input bit inject);
    int first_done = 0;
    int ndone = 0;
    int busy_err = 0;
    logic [31:0] hi_at = 32'd0;
    logic [31:0] lo_at = 32'd0;
    @(negedge clk);
    start = 1'b1; is_signed = sgn; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        if (first_done == 0) begin
          first_done = k; hi_at = hi; lo_at = lo;
        end
      end
      if (busy !== (k <= 50)) busy_err++;
      if (inject) begin
        if (k == 9) begin start = 1'b1; a = 32'd7; b = 32'd7; end
        if (k == 10) start = 1'b0;
        if (k == 19) begin lo_we = 1'b1; wdata = 32'h0000_1234; end
        if (k == 20) lo_we = 1'b0;
      end
    end
    chk({tag, "_latency"}, 32'(first_done), 32'd50);
    chk({tag, "_done_count"}, 32'(ndone), 32'd1);
    chk({tag, "_busy_profile"}, 32'(busy_err), 32'd0);
    chk({tag, "_hi"}, hi_at, eh);
    chk({tag, "_lo"}, lo_at, el);
    chk({tag, "_hi_hold"}, hi, eh);
    chk({tag, "_lo_hold"}, lo, el);
  endtask

  initial begin
    int nd;
    #12;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_mul("multu_3x5", 1'b0, 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F, 1'b0);

    // MTHI in IDLE.
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi_hi", hi, 32'hDEAD_BEEF);
    chk("mthi_lo", lo, 32'h0000_000F);
    chk("mthi_busy", {31'd0, busy}, 32'd0);

    run_mul("multu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_mul("mult_m2x3", 1'b1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    run_mul("mult_min2", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    run_mul("mult_zero", 1'b1, 32'd0, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0);
    run_mul("interlock", 1'b0, 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F, 1'b1);
    run_mul("mult_5xm3", 1'b1, 32'd5, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);

    // Reset in the middle of a multiply.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (24) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) nd++;
    end
    chk("midrst_quiet", 32'(nd), 32'd0);

    run_mul("after_rst", 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mult_seq_hilo.md
Name: mult_seq_hilo

Overview:
- Multi-cycle MIPS MULT/MULTU execution unit built around the existing 5x5 unsigned Wallace core (wallace_five, 10-bit product).
- Sequences 5-bit operand digits into one core instance each cycle, accumulates shifted partial products, applies sign correction, and owns the architectural HI/LO registers.
- Also services MTHI/MTLO writes. The pipeline stalls on busy for MFHI/MFLO/MULT hazards.

Parameters:
- WIDTH, 32, operand width; fixed at 32 for this revision.
- DIGITS, 7, 5-bit digits per operand, equal to ceil((WIDTH+3)/5) after zero-extension to 35 bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a multiply; sampled only in IDLE.
- is_signed  in  1  1 = MULT (two's complement), 0 = MULTU; sampled with start.
- a  in  32  multiplicand (rs); sampled with start.
- b  in  32  multiplier (rt); sampled with start.
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wdata  in  32  MTHI/MTLO data.
- busy  out  1  high while state != IDLE.
- done  out  1  single-cycle pulse when HI/LO take the product.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; hi=0, lo=0, busy=0, done=0; accumulator, digit counters and sign flag cleared. Reset mid-operation aborts the multiply with no done pulse and no HI/LO update.
- States:
  - IDLE: on start=1, latch magnitudes and go to CALC. Magnitude is |x| if is_signed and x[31]=1, else x, as 32-bit unsigned; |0x80000000| = 0x80000000. Also set neg = is_signed & (a[31]^b[31]), acc=0, i=0, j=0.
  - CALC: each cycle, the core computes ma_digit[i] * mb_digit[j] (10 bits), where digit k is bits [5k+4:5k] of the 35-bit zero-extended magnitude. Update acc <= acc + (product << 5*(i+j)), truncated to 64 bits (the true magnitude product always fits). Advance j; when j=6, set j=0 and i=i+1. After the (i=6, j=6) accumulation, go to FIX. Exactly 49 accumulate cycles.
  - FIX: {hi,lo} <= neg ? (~acc + 1) : acc; done=1 for this one cycle (registered, coincident with the HI/LO update); go to IDLE.
- Latency: start sampled at edge E0. CALC covers edges E1..E49. HI/LO update and done rise at edge E50. busy is 1 from after E0 through E50 and drops when done drops. Back-to-back start is accepted at the edge following the done pulse.
- start while busy: ignored, with no queuing.
- hi_we/lo_we:
  - In IDLE, written at the next edge.
  - While busy, dropped; HI/LO are untouched and the product overwrites both at FIX.
  - start and hi_we/lo_we in the same IDLE cycle: the write takes effect now; the product overwrites it 50 cycles later.
- done and busy are never driven combinationally from inputs.
- Product rules: a zero operand gives hi=lo=0 regardless of sign (no negative zero). hi/lo hold their value indefinitely outside FIX and MT writes.

Test Plan:
- Unsigned small: MULTU a=3, b=5 -> busy high for 50 cycles; done pulses once at E50; hi=0x00000000, lo=0x0000000F.
- Unsigned max: MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Signed:
  - MULT a=0xFFFFFFFE (-2), b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - MULT a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
  - MULT a=0, b=0xFFFFFFFF -> hi=lo=0.
- Busy interlock: a second start (a=7, b=7) at E10 of a 3*5 MULTU, plus lo_we=1 with wdata=0x1234 at E20 -> both ignored; result stays lo=0x0F; no second done.
- MT path: in IDLE, hi_we=1, wdata=0xDEADBEEF -> hi=0xDEADBEEF next cycle, lo unchanged, busy stays 0.
- Reset mid-op: assert rst_n=0 at E25 of a MULTU -> hi=lo=0, busy=0 immediately (async); no done; a fresh start after release completes normally in 50 cycles.
